// File: rtl/ddr3_arbiter_pkg.sv
// Shared types and constants for the two-master DDR3 word-interface arbiter.
package ddr3_arbiter_pkg;

  typedef logic master_id_t;

  localparam master_id_t MASTER_CPU = 1'b0;
  localparam master_id_t MASTER_AUX = 1'b1;

  localparam int unsigned DDR_WORD_ADDR_W = 25;

endpackage

// File: rtl/ddr3_arbiter_fifo.sv
// Synchronous FIFO with combinational head; push while full is honoured only alongside a pop.
module ddr3_arbiter_fifo #(
  parameter int unsigned data_width = 1,
  parameter int unsigned depth_bits = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [data_width-1:0] head,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned DEPTH = 1 << depth_bits;
  localparam int unsigned PTR_W = depth_bits;
  localparam int unsigned CNT_W = depth_bits + 1;

  logic [data_width-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == CNT_W'(0));
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ddr3_arbiter.sv
// Round-robin arbiter of two masters onto one DDR3 word port with in-order read-response routing.
// Optional DDR3_ARBITER_PERF_EN adds saturating grant and tag-full stall counters.
module ddr3_arbiter
  import ddr3_arbiter_pkg::*;
#(
  parameter int unsigned TAG_DEPTH_BITS = 4
) (
  input  logic                       reset_n,
  input  logic                       clk,
  output logic                       m0_ready,
  input  logic [DDR_WORD_ADDR_W-1:0] m0_addr,
  input  logic [31:0]                m0_write_data,
  input  logic [3:0]                 m0_byte_enable,
  input  logic                       m0_write_req,
  input  logic                       m0_read_req,
  output logic [31:0]                m0_read_data,
  output logic                       m0_read_data_valid,
  output logic                       m1_ready,
  input  logic [DDR_WORD_ADDR_W-1:0] m1_addr,
  input  logic [31:0]                m1_write_data,
  input  logic [3:0]                 m1_byte_enable,
  input  logic                       m1_write_req,
  input  logic                       m1_read_req,
  output logic [31:0]                m1_read_data,
  output logic                       m1_read_data_valid,
  input  logic                       ddr_ready,
  output logic [DDR_WORD_ADDR_W-1:0] ddr_addr,
  output logic [31:0]                ddr_write_data,
  output logic [3:0]                 ddr_byte_enable,
  output logic                       ddr_write_req,
  output logic                       ddr_read_req,
  input  logic [31:0]                ddr_read_data,
  input  logic                       ddr_read_data_valid
`ifdef DDR3_ARBITER_PERF_EN
  ,
  output logic [31:0]                m0_grant_count,
  output logic [31:0]                m1_grant_count,
  output logic [31:0]                tag_full_stall_count
`endif
);

  master_id_t last_grant;
  master_id_t grant;
  master_id_t tag_head;
  logic       req0;
  logic       req1;
  logic       grant_read;
  logic       grant_write;
  logic       read_blocked;
  logic       accept_ok;
  logic       accepted;
  logic       tag_push;
  logic       tag_pop;
  logic       tag_empty;
  logic       tag_full;

  assign req0 = m0_read_req | m0_write_req;
  assign req1 = m1_read_req | m1_write_req;

  // Tie goes to the master that did not win last; idle keeps the previous owner.
  always_comb begin
    grant = last_grant;
    if (req0 && req1) grant = ~last_grant;
    else if (req0)    grant = MASTER_CPU;
    else if (req1)    grant = MASTER_AUX;
  end

  assign grant_read   = (grant == MASTER_AUX) ? m1_read_req  : m0_read_req;
  assign grant_write  = (grant == MASTER_AUX) ? m1_write_req : m0_write_req;
  assign read_blocked = tag_full && grant_read;
  assign accept_ok    = reset_n && ddr_ready && !read_blocked;
  assign accepted     = accept_ok && (grant_read || grant_write);

  assign m0_ready = accept_ok && (grant == MASTER_CPU);
  assign m1_ready = accept_ok && (grant == MASTER_AUX);

  assign ddr_addr        = (grant == MASTER_AUX) ? m1_addr        : m0_addr;
  assign ddr_write_data  = (grant == MASTER_AUX) ? m1_write_data  : m0_write_data;
  assign ddr_byte_enable = (grant == MASTER_AUX) ? m1_byte_enable : m0_byte_enable;
  assign ddr_read_req    = reset_n && grant_read && !read_blocked;
  assign ddr_write_req   = reset_n && grant_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      last_grant <= MASTER_AUX;
    else if (accepted) last_grant <= grant;
  end

  assign tag_push = accepted && grant_read;
  assign tag_pop  = ddr_read_data_valid && !tag_empty;

  ddr3_arbiter_fifo #(
    .data_width (1),
    .depth_bits (TAG_DEPTH_BITS)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tag_push),
    .push_data (grant),
    .pop       (tag_pop),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  // Responses with no outstanding tag are dropped.
  assign m0_read_data       = ddr_read_data;
  assign m1_read_data       = ddr_read_data;
  assign m0_read_data_valid = tag_pop && (tag_head == MASTER_CPU);
  assign m1_read_data_valid = tag_pop && (tag_head == MASTER_AUX);

`ifdef DDR3_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_grant_count       <= '0;
      m1_grant_count       <= '0;
      tag_full_stall_count <= '0;
    end else begin
      if (accepted && (grant == MASTER_CPU) && (m0_grant_count != '1))
        m0_grant_count <= m0_grant_count + 32'd1;
      if (accepted && (grant == MASTER_AUX) && (m1_grant_count != '1))
        m1_grant_count <= m1_grant_count + 32'd1;
      if (read_blocked && (tag_full_stall_count != '1))
        tag_full_stall_count <= tag_full_stall_count + 32'd1;
    end
  end
`endif

endmodule
